sseg_mux_n: RTL

SSEG_MUX_N -- requirements
Module: sseg_mux_n

---
 rtl/sseg_pkg.sv | 12 +
 rtl/sseg_hex_dec.sv | 9 +
 rtl/sseg_mux_n.sv | 91 +++++++++
 3 files changed

// File: rtl/sseg_pkg.sv
// sseg_pkg: shared constants for the seven-segment multiplexer.
// Holds the active-low hex glyph table, the blank code and the NUM_DIGITS legal range.
package sseg_pkg;
    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam int NUM_DIGITS_MIN = 1;
    localparam int NUM_DIGITS_MAX = 8;
    // Active-low g..a codes, entry 15 first so SEG_TABLE[n] yields the glyph for nibble n.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };
endpackage

// File: rtl/sseg_hex_dec.sv
// sseg_hex_dec: combinational hex nibble to active-low g..a segment decode.
module sseg_hex_dec
    import sseg_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);
    assign seg_o = SEG_TABLE[nib_i];
endmodule

// File: rtl/sseg_mux_n.sv
// sseg_mux_n: time-multiplexed N-digit seven-segment driver with shadow/active double buffering.
// Define SSEG_LZ_BLANK_EN to blank leading-zero digits (digit 0 is always shown).
module sseg_mux_n
    import sseg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DIV        = 50000
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp,
    output logic [7:0]              segments,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done,
    output logic                    pending
);
    localparam int CW = $clog2(DIV);
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;

    if (NUM_DIGITS < NUM_DIGITS_MIN || NUM_DIGITS > NUM_DIGITS_MAX) begin : g_bad_num_digits
        $error("sseg_mux_n: NUM_DIGITS out of range");
    end

    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] sh_val_q, sh_val_d, act_val_q, act_val_d;
    logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d, act_dp_q, act_dp_d, an_q, an_d;
    logic [7:0]              seg_q, seg_d;
    logic                    pend_q, pend_d;
    logic                    tick, wrap, blank;
    logic [3:0]              nib;
    logic [6:0]              hex_seg;

    assign tick       = cnt_q == CW'(DIV - 1);
    assign wrap       = idx_q == IW'(NUM_DIGITS - 1);
    // Combinational so a load in this cycle coincides with the commit edge.
    assign frame_done = tick && wrap && !RST;
    assign nib        = act_val_q[{idx_q, 2'b00} +: 4];
    assign segments   = seg_q;
    assign an         = an_q;
    assign pending    = pend_q;

`ifdef SSEG_LZ_BLANK_EN
    assign blank = idx_q != '0 && (act_val_q >> {idx_q, 2'b00}) == '0;
`else
    assign blank = 1'b0;
`endif

    sseg_hex_dec u_dec (
        .nib_i (nib),
        .seg_o (hex_seg)
    );

    always_comb begin
        cnt_d     = tick ? '0 : cnt_q + 1'b1;
        idx_d     = tick ? (wrap ? '0 : idx_q + 1'b1) : idx_q;
        sh_val_d  = load ? value : sh_val_q;
        sh_dp_d   = load ? dp : sh_dp_q;
        act_val_d = frame_done && pend_q ? sh_val_q : act_val_q;
        act_dp_d  = frame_done && pend_q ? sh_dp_q : act_dp_q;
        pend_d    = load || (pend_q && !frame_done);
        an_d      = ~(NUM_DIGITS'(1) << idx_q);
        seg_d     = {~act_dp_q[idx_q], blank ? 7'h7F : hex_seg};
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            sh_val_q  <= '0;
            sh_dp_q   <= '0;
            act_val_q <= '0;
            act_dp_q  <= '0;
            pend_q    <= 1'b0;
            an_q      <= '1;
            seg_q     <= SEG_OFF;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            sh_val_q  <= sh_val_d;
            sh_dp_q   <= sh_dp_d;
            act_val_q <= act_val_d;
            act_dp_q  <= act_dp_d;
            pend_q    <= pend_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
        end
    end
endmodule
